// File: rtl/sphere_pair_dispatcher.sv
// Pair sequencer for the sphere-sphere collider: walks every i<j pair of a host-loaded
// sphere table, restarts the collider per pair and forwards contacts on a valid/ready stream.
module sphere_pair_dispatcher #(
    parameter int N_MAX   = 16,
    parameter int AW      = 4,
    parameter int RST_CYC = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_x,
    input  logic [31:0]   wr_y,
    input  logic [31:0]   wr_z,
    input  logic [31:0]   wr_r,
    input  logic [AW:0]   n_spheres,
    input  logic          start,
    output logic          busy,
    output logic          sweep_done,
    output logic [31:0]   x1,
    output logic [31:0]   y1,
    output logic [31:0]   z1,
    output logic [31:0]   r1,
    output logic [31:0]   x2,
    output logic [31:0]   y2,
    output logic [31:0]   z2,
    output logic [31:0]   r2,
    output logic [31:0]   g1,
    output logic [31:0]   g2,
    output logic          coll_rst,
    input  logic          coll_done,
    input  logic          coll_ret,
    input  logic [31:0]   cx,
    input  logic [31:0]   cy,
    input  logic [31:0]   cz,
    input  logic [31:0]   normalx,
    input  logic [31:0]   normaly,
    input  logic [31:0]   normalz,
    input  logic [31:0]   depth,
    output logic          ct_valid,
    input  logic          ct_ready,
    output logic [31:0]   ct_cx,
    output logic [31:0]   ct_cy,
    output logic [31:0]   ct_cz,
    output logic [31:0]   ct_nx,
    output logic [31:0]   ct_ny,
    output logic [31:0]   ct_nz,
    output logic [31:0]   ct_depth,
    output logic [AW-1:0] ct_g1,
    output logic [AW-1:0] ct_g2,
    output logic [15:0]   contact_cnt,
    output logic [15:0]   timeout_cnt
);

    localparam int          WCW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int          RCW   = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [AW:0] N_LIM = (AW+1)'(N_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RESET, S_WAIT, S_EMIT, S_NEXT, S_FINISH
    } state_t;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [31:0] r;
    } sphere_t;

    typedef struct packed {
        logic [31:0]   cx;
        logic [31:0]   cy;
        logic [31:0]   cz;
        logic [31:0]   nx;
        logic [31:0]   ny;
        logic [31:0]   nz;
        logic [31:0]   depth;
        logic [AW-1:0] g1;
        logic [AW-1:0] g2;
    } contact_t;

    sphere_t tab [N_MAX];

    state_t         state_q, state_d;
    logic [AW:0]    n_q, n_d, n_start;
    logic [AW-1:0]  i_q, i_d, j_q, j_d;
    logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           busy_q, busy_d;
    logic           sweep_done_q, sweep_done_d;
    logic           coll_rst_q, coll_rst_d;
    sphere_t        s1_q, s1_d, s2_q, s2_d;
    logic [31:0]    g1_q, g1_d, g2_q, g2_d;
    logic           ct_valid_q, ct_valid_d;
    contact_t       ct_q, ct_d;
    logic [15:0]    contact_cnt_q, contact_cnt_d;
    logic [15:0]    timeout_cnt_q, timeout_cnt_d;

    // NOTE: the table is plain storage with no reset, so it maps onto RAM/LUT-RAM; the
    // sweep only ever reads entries the host has written.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_q && ({1'b0, wr_addr} < N_LIM))
            tab[wr_addr] <= '{x: wr_x, y: wr_y, z: wr_z, r: wr_r};
    end

    assign n_start = (n_spheres > N_LIM) ? N_LIM : n_spheres;

    always_comb begin
        // NOTE: every _d starts from its _q so that no path through the case leaves a
        // signal unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        n_d           = n_q;
        i_d           = i_q;
        j_d           = j_q;
        rst_cnt_d     = rst_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        sweep_done_d  = 1'b0;
        s1_d          = s1_q;
        s2_d          = s2_q;
        g1_d          = g1_q;
        g2_d          = g2_q;
        ct_valid_d    = ct_valid_q;
        ct_d          = ct_q;
        contact_cnt_d = contact_cnt_q;
        timeout_cnt_d = timeout_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d           = n_start;
                    contact_cnt_d = '0;
                    timeout_cnt_d = '0;
                    i_d           = '0;
                    j_d           = AW'(1);
                    state_d       = (n_start < (AW+1)'(2)) ? S_FINISH : S_LOAD;
                end
            end
            S_LOAD: begin
                s1_d      = tab[i_q];
                s2_d      = tab[j_q];
                g1_d      = 32'(i_q);
                g2_d      = 32'(j_q);
                rst_cnt_d = '0;
                state_d   = S_RESET;
            end
            S_RESET: begin
                if (rst_cnt_q == RCW'(RST_CYC - 1)) begin
                    wait_cnt_d = '0;
                    state_d    = S_WAIT;
                end else begin
                    rst_cnt_d = rst_cnt_q + RCW'(1);
                end
            end
            S_WAIT: begin
                if (coll_done) begin
                    if (coll_ret) begin
                        ct_d       = '{cx: cx, cy: cy, cz: cz, nx: normalx, ny: normaly,
                                       nz: normalz, depth: depth, g1: i_q, g2: j_q};
                        ct_valid_d = 1'b1;
                        state_d    = S_EMIT;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
                    if (timeout_cnt_q != 16'hFFFF) timeout_cnt_d = timeout_cnt_q + 16'd1;
                    state_d = S_NEXT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            S_EMIT: begin
                if (ct_ready) begin
                    if (contact_cnt_q != 16'hFFFF) contact_cnt_d = contact_cnt_q + 16'd1;
                    ct_valid_d = 1'b0;
                    state_d    = S_NEXT;
                end
            end
            S_NEXT: begin
                if ({1'b0, j_q} < n_q - (AW+1)'(1)) begin
                    j_d     = j_q + AW'(1);
                    state_d = S_LOAD;
                end else if ({1'b0, i_q} < n_q - (AW+1)'(2)) begin
                    i_d     = i_q + AW'(1);
                    j_d     = i_q + AW'(2);
                    state_d = S_LOAD;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                sweep_done_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Registered outputs follow the state being entered, so they line up with it.
        busy_d     = (state_d != S_IDLE);
        coll_rst_d = (state_d == S_WAIT) || (state_d == S_EMIT);
    end

    // NOTE: all state updates use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            n_q           <= '0;
            i_q           <= '0;
            j_q           <= '0;
            rst_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            busy_q        <= 1'b0;
            sweep_done_q  <= 1'b0;
            coll_rst_q    <= 1'b0;
            s1_q          <= '0;
            s2_q          <= '0;
            g1_q          <= '0;
            g2_q          <= '0;
            ct_valid_q    <= 1'b0;
            ct_q          <= '0;
            contact_cnt_q <= '0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            i_q           <= i_d;
            j_q           <= j_d;
            rst_cnt_q     <= rst_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            busy_q        <= busy_d;
            sweep_done_q  <= sweep_done_d;
            coll_rst_q    <= coll_rst_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            g1_q          <= g1_d;
            g2_q          <= g2_d;
            ct_valid_q    <= ct_valid_d;
            ct_q          <= ct_d;
            contact_cnt_q <= contact_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign busy        = busy_q;
    assign sweep_done  = sweep_done_q;
    assign coll_rst    = coll_rst_q;
    assign x1          = s1_q.x;
    assign y1          = s1_q.y;
    assign z1          = s1_q.z;
    assign r1          = s1_q.r;
    assign x2          = s2_q.x;
    assign y2          = s2_q.y;
    assign z2          = s2_q.z;
    assign r2          = s2_q.r;
    assign g1          = g1_q;
    assign g2          = g2_q;
    assign ct_valid    = ct_valid_q;
    assign ct_cx       = ct_q.cx;
    assign ct_cy       = ct_q.cy;
    assign ct_cz       = ct_q.cz;
    assign ct_nx       = ct_q.nx;
    assign ct_ny       = ct_q.ny;
    assign ct_nz       = ct_q.nz;
    assign ct_depth    = ct_q.depth;
    assign ct_g1       = ct_q.g1;
    assign ct_g2       = ct_q.g2;
    assign contact_cnt = contact_cnt_q;
    assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_sphere_pair_dispatcher.sv
// Scoreboard bench for sphere_pair_dispatcher: a behavioural collider answers each pair,
// expected pairs and contacts are queued at start and retired as the DUT presents them.
module tb_sphere_pair_dispatcher;

    localparam int N_MAX   = 16;
    localparam int AW      = 4;
    localparam int RST_CYC = 2;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          rst, wr_en, start, coll_done, coll_ret, ct_ready;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_x, wr_y, wr_z, wr_r;
    logic [AW:0]   n_spheres;
    logic          busy, sweep_done, coll_rst, ct_valid;
    logic [31:0]   x1, y1, z1, r1, x2, y2, z2, r2, g1, g2;
    logic [31:0]   cx, cy, cz, normalx, normaly, normalz, depth;
    logic [31:0]   ct_cx, ct_cy, ct_cz, ct_nx, ct_ny, ct_nz, ct_depth;
    logic [AW-1:0] ct_g1, ct_g2;
    logic [15:0]   contact_cnt, timeout_cnt;

    always #5 clk = ~clk;

    sphere_pair_dispatcher #(.N_MAX(N_MAX), .AW(AW), .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_x(wr_x), .wr_y(wr_y), .wr_z(wr_z), .wr_r(wr_r),
        .n_spheres(n_spheres), .start(start), .busy(busy), .sweep_done(sweep_done),
        .x1(x1), .y1(y1), .z1(z1), .r1(r1), .x2(x2), .y2(y2), .z2(z2), .r2(r2),
        .g1(g1), .g2(g2), .coll_rst(coll_rst), .coll_done(coll_done), .coll_ret(coll_ret),
        .cx(cx), .cy(cy), .cz(cz), .normalx(normalx), .normaly(normaly), .normalz(normalz),
        .depth(depth), .ct_valid(ct_valid), .ct_ready(ct_ready),
        .ct_cx(ct_cx), .ct_cy(ct_cy), .ct_cz(ct_cz), .ct_nx(ct_nx), .ct_ny(ct_ny),
        .ct_nz(ct_nz), .ct_depth(ct_depth), .ct_g1(ct_g1), .ct_g2(ct_g2),
        .contact_cnt(contact_cnt), .timeout_cnt(timeout_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Reference table and per-pair collider behaviour.
    logic [31:0] m_x [N_MAX];
    logic [31:0] m_y [N_MAX];
    logic [31:0] m_z [N_MAX];
    logic [31:0] m_r [N_MAX];
    int          lat_cfg  [N_MAX][N_MAX];
    bit          ret_cfg  [N_MAX][N_MAX];
    bit          hang_cfg [N_MAX][N_MAX];
    logic [31:0] dep_cfg  [N_MAX][N_MAX];

    // Collider model: counts cycles out of reset, answers after the pair's latency.
    int         ccnt;
    logic [3:0] mg1, mg2;
    assign mg1 = g1[3:0];
    assign mg2 = g2[3:0];
    always @(posedge clk) begin
        if (!coll_rst) ccnt <= 0;
        else           ccnt <= ccnt + 1;
    end
    assign coll_done = coll_rst && !hang_cfg[mg1][mg2] && (ccnt >= lat_cfg[mg1][mg2]);
    assign coll_ret  = ret_cfg[mg1][mg2];
    assign cx        = 32'hA000_0000 | {24'h0, mg1, mg2};
    assign cy        = 32'hB000_0000 | {24'h0, mg1, mg2};
    assign cz        = 32'hC000_0000 | {24'h0, mg1, mg2};
    assign normalx   = 32'hD000_0000 | {24'h0, mg1, mg2};
    assign normaly   = 32'hE000_0000 | {24'h0, mg1, mg2};
    assign normalz   = 32'hF000_0000 | {24'h0, mg1, mg2};
    assign depth     = dep_cfg[mg1][mg2];

    typedef struct packed { logic [3:0] i; logic [3:0] j; } pair_t;
    typedef struct packed { logic [3:0] i; logic [3:0] j; logic [31:0] depth; } exp_ct_t;
    pair_t   pair_q [$];
    exp_ct_t exp_ct_q [$];
    int      exp_contacts, exp_timeouts;

    // Monitor state (sampled on the falling edge).
    logic        prev_cr;
    int          high_cnt, vrun, last_vrun, xfer_cnt, pairs_seen;
    logic [3:0]  cur_i, cur_j;
    logic [63:0] cap_ops;
    logic [7:0]  cap_g;

    initial begin
        prev_cr = 1'b0; high_cnt = 0; vrun = 0; last_vrun = 0; xfer_cnt = 0; pairs_seen = 0;
        cur_i = '0; cur_j = '0; cap_ops = '0; cap_g = '0;
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_cr  <= 1'b0;
            high_cnt <= 0;
            vrun     <= 0;
        end else begin
            if (coll_rst && !prev_cr) begin
                if (pair_q.size() == 0) begin
                    check("pair_unexpected", pair_q.size(), 1);
                end else begin
                    check("pair_g1", g1, pair_q[0].i);
                    check("pair_g2", g2, pair_q[0].j);
                    check("pair_s1", {x1, r1}, {m_x[pair_q[0].i], m_r[pair_q[0].i]});
                    check("pair_s1_yz", {y1, z1}, {m_y[pair_q[0].i], m_z[pair_q[0].i]});
                    check("pair_s2", {x2, r2}, {m_x[pair_q[0].j], m_r[pair_q[0].j]});
                    check("pair_s2_yz", {y2, z2}, {m_y[pair_q[0].j], m_z[pair_q[0].j]});
                    cur_i <= pair_q[0].i;
                    cur_j <= pair_q[0].j;
                    void'(pair_q.pop_front());
                end
                cap_ops    <= {x1, r2};
                cap_g      <= {g1[3:0], g2[3:0]};
                high_cnt   <= 1;
                pairs_seen <= pairs_seen + 1;
            end else if (coll_rst) begin
                high_cnt <= high_cnt + 1;
            end
            if (!coll_rst && prev_cr) begin
                if (hang_cfg[cur_i][cur_j])
                    check("timeout_len", high_cnt, TIMEOUT);
                else if (!ret_cfg[cur_i][cur_j])
                    check("wait_len", high_cnt, lat_cfg[cur_i][cur_j] + 1);
                check("ops_stable", {x1, r2}, cap_ops);
                check("g_stable", {g1[3:0], g2[3:0]}, cap_g);
            end
            if (ct_valid && ct_ready) begin
                xfer_cnt <= xfer_cnt + 1;
                if (exp_ct_q.size() == 0) begin
                    check("contact_unexpected", exp_ct_q.size(), 1);
                end else begin
                    check("ct_g", {ct_g1, ct_g2}, {exp_ct_q[0].i, exp_ct_q[0].j});
                    check("ct_depth", ct_depth, exp_ct_q[0].depth);
                    check("ct_cxyz", {ct_cx, ct_cz},
                          {32'hA000_0000 | {24'h0, exp_ct_q[0].i, exp_ct_q[0].j},
                           32'hC000_0000 | {24'h0, exp_ct_q[0].i, exp_ct_q[0].j}});
                    check("ct_norm", {ct_ny, ct_nz},
                          {32'hE000_0000 | {24'h0, exp_ct_q[0].i, exp_ct_q[0].j},
                           32'hF000_0000 | {24'h0, exp_ct_q[0].i, exp_ct_q[0].j}});
                    void'(exp_ct_q.pop_front());
                end
            end
            if (ct_valid) begin
                vrun <= vrun + 1;
            end else begin
                if (vrun != 0) last_vrun <= vrun;
                vrun <= 0;
            end
            prev_cr <= coll_rst;
        end
    end

    task automatic wr_sphere(input int idx, input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] z, input logic [31:0] r);
        wr_en = 1'b1; wr_addr = AW'(idx); wr_x = x; wr_y = y; wr_z = z; wr_r = r;
        @(posedge clk); #1;
        wr_en = 1'b0;
        m_x[idx] = x; m_y[idx] = y; m_z[idx] = z; m_r[idx] = r;
    endtask

    task automatic cfg_all(input int lat, input bit ret);
        for (int a = 0; a < N_MAX; a++)
            for (int b = 0; b < N_MAX; b++) begin
                lat_cfg[a][b]  = lat;
                ret_cfg[a][b]  = ret;
                hang_cfg[a][b] = 1'b0;
                dep_cfg[a][b]  = 32'h3E00_0000 | {24'h0, 4'(a), 4'(b)};
            end
    endtask

    // Queue the expected pair walk and contacts, then pulse start (called in IDLE).
    task automatic launch(input int n_req);
        int n;
        n = (n_req > N_MAX) ? N_MAX : n_req;
        exp_contacts = 0;
        exp_timeouts = 0;
        for (int a = 0; a < n; a++)
            for (int b = a + 1; b < n; b++) begin
                pair_q.push_back('{i: 4'(a), j: 4'(b)});
                if (hang_cfg[a][b]) begin
                    exp_timeouts++;
                end else if (ret_cfg[a][b]) begin
                    exp_ct_q.push_back('{i: 4'(a), j: 4'(b), depth: dep_cfg[a][b]});
                    exp_contacts++;
                end
            end
        n_spheres = (AW+1)'(n_req);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic finish_sweep(input int exp_cyc);
        int cyc;
        bit seen;
        cyc  = 1;
        seen = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (sweep_done) begin
                seen = 1'b1;
                break;
            end
            cyc++;
        end
        check("sweep_done_seen", seen, 1);
        if (seen) begin
            if (exp_cyc > 0) check("sweep_latency", cyc, exp_cyc);
            check("busy_at_done", busy, 0);
            check("contact_cnt", contact_cnt, exp_contacts);
            check("timeout_cnt", timeout_cnt, exp_timeouts);
            check("pairs_left", pair_q.size(), 0);
            check("contacts_left", exp_ct_q.size(), 0);
        end
        @(posedge clk); #1;
        check("sweep_done_pulse", sweep_done, 0);
    endtask

    initial begin
        int  xfer0, seen0, falls;
        bit  prev_m, got;
        logic [63:0] snap;
        logic [7:0]  snap_g;

        rst = 1'b1; wr_en = 1'b0; start = 1'b0; ct_ready = 1'b1;
        wr_addr = '0; wr_x = '0; wr_y = '0; wr_z = '0; wr_r = '0; n_spheres = '0;
        cfg_all(10, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_sweep_done", sweep_done, 0);
        check("rst_ct_valid", ct_valid, 0);
        check("rst_coll_rst", coll_rst, 0);
        check("rst_ops", {x1, r2}, 0);
        check("rst_g", {g1, g2}, 0);
        check("rst_counters", {contact_cnt, timeout_cnt}, 0);
        check("rst_ct_depth", ct_depth, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Touching spheres: one contact after a 40-cycle collider.
        wr_sphere(0, 32'h0, 32'h0, 32'h0, 32'h3F80_0000);
        wr_sphere(1, 32'h3FC0_0000, 32'h0, 32'h0, 32'h3F80_0000);
        lat_cfg[0][1] = 40; ret_cfg[0][1] = 1'b1; dep_cfg[0][1] = 32'h3F00_0000;
        launch(2);
        finish_sweep(0);
        check("valid_one_cycle", last_vrun, 1);

        // n=4, all misses: order of pairs checked by the monitor.
        for (int k = 2; k < N_MAX; k++)
            wr_sphere(k, 32'h4100_0000 + k, 32'h4200_0000 + k, 32'h4300_0000 + k,
                      32'h3F00_0000 + k);
        cfg_all(10, 1'b0);
        launch(4);
        finish_sweep(0);

        // n=3 with pair (1,2) never answering.
        cfg_all(5, 1'b0);
        hang_cfg[1][2] = 1'b1;
        launch(3);
        finish_sweep(0);

        // Backpressure: contact held 20+ cycles, table write while busy must be dropped.
        cfg_all(5, 1'b0);
        ret_cfg[0][1] = 1'b1; dep_cfg[0][1] = 32'h4049_0FDB;
        ct_ready = 1'b0;
        launch(2);
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ct_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("ct_valid_seen", got, 1);
        snap   = {ct_depth, ct_cx};
        snap_g = {ct_g1, ct_g2};
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = '0; wr_x = 32'hDEAD_BEEF; wr_r = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        wr_en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("bp_valid", ct_valid, 1);
            check("bp_fields", {ct_depth, ct_cx}, snap);
            check("bp_idx", {ct_g1, ct_g2}, snap_g);
        end
        @(posedge clk); #1;
        xfer0 = xfer_cnt;
        ct_ready = 1'b1;
        finish_sweep(0);
        check("bp_one_transfer", xfer_cnt - xfer0, 1);

        // n=1: immediate finish two cycles after start.
        launch(1);
        finish_sweep(2);

        // n_spheres=31 clamps to 16: 120 pairs, scattered contacts.
        cfg_all(2, 1'b0);
        for (int a = 0; a < N_MAX; a++)
            for (int b = a + 1; b < N_MAX; b++)
                if ((a + b) % 5 == 0) ret_cfg[a][b] = 1'b1;
        seen0 = pairs_seen;
        launch(31);
        finish_sweep(0);
        check("clamp_pairs", pairs_seen - seen0, 120);

        // Reset during RESET of the third pair, then a clean restart.
        cfg_all(10, 1'b0);
        ret_cfg[0][1] = 1'b1;
        launch(4);
        falls  = 0;
        prev_m = 1'b0;
        for (int k = 0; k < 2000 && falls < 2; k++) begin
            @(negedge clk);
            if (prev_m && !coll_rst) falls++;
            prev_m = coll_rst;
        end
        check("mid_two_pairs", falls, 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_in_reset", coll_rst, 0);
        check("mid_pair3", {g1[3:0], g2[3:0]}, 8'h03);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_coll_rst", coll_rst, 0);
        check("mid_rst_counters", {contact_cnt, timeout_cnt}, 0);
        check("mid_rst_g", {g1, g2}, 0);
        check("mid_rst_ops", {x1, r2}, 0);
        rst = 1'b0;
        pair_q.delete();
        exp_ct_q.delete();
        @(posedge clk); #1;
        launch(4);
        finish_sweep(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
